// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate sequential multiplier: FSM states,
// default geometry and the low-column mask helper.
package approx_mult_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_APPROX_COLS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Mask with the low min(cols, width) bits set; callers cast to their width.
    function automatic logic [63:0] lo_mask(input int width, input int cols);
        logic [63:0] m;
        m = '0;
        for (int k = 0; k < 64; k++) begin
            if (k < cols && k < width) m[k] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/approx_seq_multiplier_if.sv
// Operand/result handshake bundle between a producer and the multiplier.
interface approx_seq_multiplier_if #(
    parameter int WIDTH = approx_mult_pkg::DEF_WIDTH
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_approx;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_result;
    logic                 out_approx;

    modport master (
        output in_valid, in_a, in_b, in_approx, out_ready,
        input  in_ready, out_valid, out_result, out_approx
    );

    modport slave (
        input  in_valid, in_a, in_b, in_approx, out_ready,
        output in_ready, out_valid, out_result, out_approx
    );
endinterface

// File: rtl/approx_column_accum.sv
// One iteration of the column accumulator: exact add above the mask,
// carry-free OR-compression below it when approximating.
module approx_column_accum #(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] pp,
    input  logic             approx,
    input  logic [ACC_W-1:0] mask,
    input  logic [ACC_W-1:0] hi_acc,
    input  logic [ACC_W-1:0] lo_or,
    output logic [ACC_W-1:0] hi_nxt,
    output logic [ACC_W-1:0] lo_nxt
);

    always_comb begin
        hi_nxt = hi_acc + pp;
        lo_nxt = lo_or;
        if (approx) begin
            hi_nxt = hi_acc + (pp & ~mask);
            lo_nxt = lo_or | (pp & mask);
        end
    end

endmodule

// File: rtl/approx_seq_multiplier.sv
// Iterative unsigned multiplier, one multiplier bit per cycle with early
// termination, and optional OR-compression of the low product columns.
module approx_seq_multiplier
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int APPROX_COLS = DEF_APPROX_COLS
) (
    input  logic                    clk,
    input  logic                    rst,
    approx_seq_multiplier_if.slave  bus
);

    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0] LO_MASK = PW'(lo_mask(PW, APPROX_COLS));

    generate
        if (APPROX_COLS < 0 || APPROX_COLS > 2 * WIDTH) begin : g_bad_cols
            $error("APPROX_COLS must lie in 0..2*WIDTH");
        end
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("WIDTH must lie in 2..32");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [PW-1:0]   a_sh;
    logic [WIDTH-1:0] b_sh;
    logic            mode_q;
    logic [PW-1:0]   hi_acc, lo_or, hi_nxt, lo_nxt, pp;
    logic            out_valid_q;
    logic [PW-1:0]   out_result_q;
    logic            out_approx_q;
    logic            accept, fire_out;

    assign accept   = (state_q == IDLE) && bus.in_valid;
    assign fire_out = (state_q == DONE) && out_valid_q && bus.out_ready;
    assign pp       = b_sh[0] ? a_sh : '0;

    approx_column_accum #(.ACC_W(PW)) u_accum (
        .pp     (pp),
        .approx (mode_q),
        .mask   (LO_MASK),
        .hi_acc (hi_acc),
        .lo_or  (lo_or),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Stop as soon as no set multiplier bits remain above the one just consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = RUN;
            RUN:     if (b_sh[WIDTH-1:1] == '0) state_d = DONE;
            DONE:    if (fire_out) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh   <= PW'(bus.in_a);
            b_sh   <= bus.in_b;
            mode_q <= bus.in_approx;
            hi_acc <= '0;
            lo_or  <= '0;
        end else if (state_q == RUN) begin
            a_sh   <= a_sh << 1;
            b_sh   <= b_sh >> 1;
            hi_acc <= hi_nxt;
            lo_or  <= lo_nxt;
        end
    end

    // Result registers load on the first DONE cycle and hold until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_approx_q <= 1'b0;
        end else if (state_q == DONE && !out_valid_q) begin
            out_valid_q  <= 1'b1;
            out_result_q <= hi_acc | lo_or;
            out_approx_q <= mode_q;
        end else if (fire_out) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_approx = out_approx_q;

endmodule
